// File: rtl/insn_decode_stage.sv
// Registered instruction-decode pipeline stage: decodes opcode/aluop into the control bundle,
// holds it under a valid/ready handshake, and interlocks issue for MD_LATENCY cycles after a mul/div.
module insn_decode_stage #(
    parameter int DATA_W     = 32,
    parameter int MD_LATENCY = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_insn,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_target,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_aluop,
    output logic [4:0]        out_shamt,
    output logic [16:0]       out_ctrl
);

    localparam int               CNT_W   = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [4:0] opcode, f_rd, f_rs, f_rt, f_aluop;
    logic is_r, is_addi, is_lw, is_sw, is_j, is_jal, is_jr, is_bne, is_blt, is_bex, is_setx;
    logic alu_in_b, dm_we, rwe, is_mul, is_div, illegal;

    assign opcode  = in_insn[31:27];
    assign f_rd    = in_insn[26:22];
    assign f_rs    = in_insn[21:17];
    assign f_rt    = in_insn[16:12];
    assign f_aluop = in_insn[6:2];

    assign is_r    = (opcode == OP_R);
    assign is_j    = (opcode == OP_J);
    assign is_bne  = (opcode == OP_BNE);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jr   = (opcode == OP_JR);
    assign is_addi = (opcode == OP_ADDI);
    assign is_blt  = (opcode == OP_BLT);
    assign is_sw   = (opcode == OP_SW);
    assign is_lw   = (opcode == OP_LW);
    assign is_setx = (opcode == OP_SETX);
    assign is_bex  = (opcode == OP_BEX);

    assign illegal  = ~(is_r | is_j | is_bne | is_jal | is_jr | is_addi | is_blt |
                        is_sw | is_lw | is_setx | is_bex);
    assign alu_in_b = is_addi | is_lw | is_sw;
    assign dm_we    = is_sw;
    assign rwe      = is_r | is_addi | is_lw | is_jal | is_setx;
    assign is_mul   = is_r & (f_aluop == ALU_MUL);
    assign is_div   = is_r & (f_aluop == ALU_DIV);

    logic [16:0]       dec_ctrl;
    logic [4:0]        dec_rs1, dec_rs2, dec_rd, dec_aluop;
    logic [DATA_W-1:0] dec_imm, dec_target;

    assign dec_ctrl = {is_r, is_addi, is_lw, is_sw, is_j, is_jal, is_jr, is_bne, is_blt,
                       is_bex, is_setx, alu_in_b, dm_we, rwe, is_mul, is_div, illegal};

    assign dec_imm    = {{(DATA_W-17){in_insn[16]}}, in_insn[16:0]};
    assign dec_target = {{(DATA_W-27){1'b0}}, in_insn[26:0]};

    // bex reads the exception register r30 through the second port, so rs1 is parked at r0
    always_comb begin
        dec_rs1 = f_rs;
        if (is_jr)
            dec_rs1 = f_rd;
        else if (is_bex)
            dec_rs1 = 5'd0;

        dec_rs2 = 5'd0;
        if (is_r)
            dec_rs2 = f_rt;
        else if (is_sw | is_bne | is_blt)
            dec_rs2 = f_rd;
        else if (is_bex)
            dec_rs2 = 5'd30;

        dec_rd = 5'd0;
        if (is_jal)
            dec_rd = 5'd31;
        else if (is_setx)
            dec_rd = 5'd30;
        else if (is_r | is_addi | is_lw)
            dec_rd = f_rd;

        dec_aluop = ALU_ADD;
        if (is_r)
            dec_aluop = f_aluop;
        else if (is_bne | is_blt)
            dec_aluop = ALU_SUB;
    end

    logic             held;
    logic [CNT_W-1:0] md_cnt;
    logic             fire, accept, md_issue;

    assign out_valid = held & (md_cnt == '0);
    assign fire      = out_valid & out_ready;
    assign in_ready  = ~flush & (~held | fire);
    assign accept    = in_valid & in_ready;
    // A bundle offered during flush is discarded, so it must not start the interlock
    assign md_issue  = fire & ~flush & (out_ctrl[2] | out_ctrl[1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            held       <= 1'b0;
            md_cnt     <= '0;
            out_pc     <= '0;
            out_imm    <= '0;
            out_target <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_aluop  <= '0;
            out_shamt  <= '0;
            out_ctrl   <= '0;
        end else begin
            if (flush)
                held <= 1'b0;
            else if (accept)
                held <= 1'b1;
            else if (fire)
                held <= 1'b0;

            if (accept) begin
                out_pc     <= in_pc;
                out_imm    <= dec_imm;
                out_target <= dec_target;
                out_rs1    <= dec_rs1;
                out_rs2    <= dec_rs2;
                out_rd     <= dec_rd;
                out_aluop  <= dec_aluop;
                out_shamt  <= in_insn[11:7];
                out_ctrl   <= dec_ctrl;
            end

            // Flush leaves md_cnt alone: the mul/div it guards is already in flight
            if (md_issue)
                md_cnt <= MD_LOAD;
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Self-checking bench for insn_decode_stage: directed scenarios plus randomized traffic,
// compared every cycle against a per-instruction reference model with cycle-count interlock.
module tb_insn_decode_stage;

    localparam int MD_LAT = 4;

    localparam int C_R = 16, C_ADDI = 15, C_LW = 14, C_SW = 13, C_J = 12, C_JAL = 11;
    localparam int C_JR = 10, C_BNE = 9, C_BLT = 8, C_BEX = 7, C_SETX = 6, C_ALUB = 5;
    localparam int C_DMWE = 4, C_RWE = 3, C_MUL = 2, C_DIV = 1, C_ILL = 0;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_insn, in_pc, out_pc, out_imm, out_target;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_aluop, out_shamt;
    logic [16:0] out_ctrl;

    always #5 clock = ~clock;

    insn_decode_stage #(.DATA_W(32), .MD_LATENCY(MD_LAT)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_target(out_target),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_aluop(out_aluop), .out_shamt(out_shamt), .out_ctrl(out_ctrl)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  aluop;
        logic [4:0]  shamt;
        logic [16:0] ctrl;
    } bundle_t;

    int      checks = 0, passes = 0, fails = 0, cyc = 0;
    bundle_t m_bundle = '0, nx_bundle;
    bit      m_held = 1'b0, nx_held;
    int      m_block_until = 0, nx_block_until;
    int      fire_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [16:0] cb(input int idx);
        return 17'(1) << idx;
    endfunction

    // Reference decode written per instruction, straight from the opcode table
    function automatic bundle_t ref_decode(input logic [31:0] insn, input logic [31:0] pc);
        bundle_t    b;
        logic [4:0] f_rd, f_rs, f_rt, f_alu;
        f_rd     = insn[26:22];
        f_rs     = insn[21:17];
        f_rt     = insn[16:12];
        f_alu    = insn[6:2];
        b        = '0;
        b.pc     = pc;
        b.imm    = {{15{insn[16]}}, insn[16:0]};
        b.target = {5'b0, insn[26:0]};
        b.shamt  = insn[11:7];
        b.rs1    = f_rs;
        case (insn[31:27])
            5'd0: begin
                b.ctrl  = cb(C_R) | cb(C_RWE);
                if (f_alu == 5'd6) b.ctrl = b.ctrl | cb(C_MUL);
                if (f_alu == 5'd7) b.ctrl = b.ctrl | cb(C_DIV);
                b.rs2   = f_rt;
                b.rd    = f_rd;
                b.aluop = f_alu;
            end
            5'd5:  begin b.ctrl = cb(C_ADDI) | cb(C_ALUB) | cb(C_RWE); b.rd = f_rd; end
            5'd8:  begin b.ctrl = cb(C_LW) | cb(C_ALUB) | cb(C_RWE); b.rd = f_rd; end
            5'd7:  begin b.ctrl = cb(C_SW) | cb(C_ALUB) | cb(C_DMWE); b.rs2 = f_rd; end
            5'd1:  b.ctrl = cb(C_J);
            5'd3:  begin b.ctrl = cb(C_JAL) | cb(C_RWE); b.rd = 5'd31; end
            5'd4:  begin b.ctrl = cb(C_JR); b.rs1 = f_rd; end
            5'd2:  begin b.ctrl = cb(C_BNE); b.rs2 = f_rd; b.aluop = 5'd1; end
            5'd6:  begin b.ctrl = cb(C_BLT); b.rs2 = f_rd; b.aluop = 5'd1; end
            5'd22: begin b.ctrl = cb(C_BEX); b.rs1 = 5'd0; b.rs2 = 5'd30; end
            5'd21: begin b.ctrl = cb(C_SETX) | cb(C_RWE); b.rd = 5'd30; end
            default: b.ctrl = cb(C_ILL);
        endcase
        return b;
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh, input logic [4:0] alu);
        return {op, rd, rs, rt, sh, alu, 2'b01};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [4:0]  ops [13];
        logic [31:0] w;
        int          k;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd9, 5'd31};
        w   = $urandom;
        k   = $urandom_range(0, 13);
        w[31:27] = (k == 13) ? 5'($urandom_range(0, 31)) : ops[k];
        if ($urandom_range(0, 3) == 0) w[6:2] = 5'($urandom_range(6, 7));
        return w;
    endfunction

    function automatic int first_fire_after(input int t);
        foreach (fire_q[i]) if (fire_q[i] > t) return fire_q[i];
        return -1;
    endfunction

    // Compare DUT against model at the negedge, then work out the model's next state
    task automatic checkOutput();
        bit exp_valid, exp_ready, mfire;
        exp_valid = m_held && (cyc >= m_block_until);
        exp_ready = !flush && (!m_held || (exp_valid && out_ready));
        chk("out_valid",  64'(out_valid),  64'(exp_valid));
        chk("in_ready",   64'(in_ready),   64'(exp_ready));
        chk("out_pc",     64'(out_pc),     64'(m_bundle.pc));
        chk("out_imm",    64'(out_imm),    64'(m_bundle.imm));
        chk("out_target", 64'(out_target), 64'(m_bundle.target));
        chk("out_rs1",    64'(out_rs1),    64'(m_bundle.rs1));
        chk("out_rs2",    64'(out_rs2),    64'(m_bundle.rs2));
        chk("out_rd",     64'(out_rd),     64'(m_bundle.rd));
        chk("out_aluop",  64'(out_aluop),  64'(m_bundle.aluop));
        chk("out_shamt",  64'(out_shamt),  64'(m_bundle.shamt));
        chk("out_ctrl",   64'(out_ctrl),   64'(m_bundle.ctrl));
        if (out_valid && out_ready && !flush) fire_q.push_back(cyc);

        mfire          = exp_valid && out_ready && !flush;
        nx_held        = m_held;
        nx_bundle      = m_bundle;
        nx_block_until = m_block_until;
        if (reset) begin
            nx_held        = 1'b0;
            nx_bundle      = '0;
            nx_block_until = 0;
        end else begin
            if (mfire && (m_bundle.ctrl[C_MUL] || m_bundle.ctrl[C_DIV]))
                nx_block_until = cyc + 1 + MD_LAT;
            if (flush) nx_held = 1'b0;
            else if (in_valid && exp_ready) begin
                nx_held   = 1'b1;
                nx_bundle = ref_decode(in_insn, in_pc);
            end else if (mfire) nx_held = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                                 input logic [31:0] insn, input logic [31:0] pc, input bit ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = ordy;
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        m_held        = nx_held;
        m_bundle      = nx_bundle;
        m_block_until = nx_block_until;
        cyc++;
        #1;
    endtask

    task automatic drain();
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [4:0]  sweep [13];
        logic [31:0] mul_i, add_i, addi_i;
        int          t0, tf;

        sweep  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd9, 5'd31};
        mul_i  = mk_r(5'd0, 5'd3, 5'd4, 5'd5, 5'd0, 5'd6);
        add_i  = mk_r(5'd0, 5'd6, 5'd3, 5'd7, 5'd0, 5'd0);
        addi_i = {5'd5, 5'd1, 5'd2, 17'h1FFFF};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b0;
        @(posedge clock); #1;
        $display("[TB] reset and addi");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready",  64'(in_ready),  64'(1));
        applyStimulus(1'b0, 1'b0, 1'b1, addi_i, 32'h100, 1'b1);
        chk("addi_valid", 64'(out_valid), 64'(1));
        chk("addi_imm",   64'(out_imm),   64'(32'hFFFF_FFFF));
        chk("addi_ctrl",  64'(out_ctrl),  64'(17'h08028));
        chk("addi_rd",    64'(out_rd),    64'(1));
        chk("addi_rs1",   64'(out_rs1),   64'(2));
        drain();

        $display("[TB] opcode sweep");
        foreach (sweep[i]) begin
            applyStimulus(1'b0, 1'b0, 1'b1, mk_r(sweep[i], 5'd7, 5'd9, 5'd11, 5'd3, 5'd2),
                          32'h200 + 32'(i), 1'b1);
            case (sweep[i])
                5'd3:       chk("jal_rd",   64'(out_rd),   64'(31));
                5'd21:      chk("setx_rd",  64'(out_rd),   64'(30));
                5'd22:      chk("bex_rs2",  64'(out_rs2),  64'(30));
                5'd9, 5'd31: chk("ill_ctrl", 64'(out_ctrl), 64'(1));
                default:    chk("sweep_valid", 64'(out_valid), 64'(1));
            endcase
        end
        drain();

        $display("[TB] back-pressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, mk_r(5'd5, 5'(i + 1), 5'd2, 5'd0, 5'd0, 5'(i)),
                          32'h300 + 32'(i), 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, mk_r(5'd8, 5'(i + 4), 5'd2, 5'd0, 5'd0, 5'(i)),
                          32'h310 + 32'(i), 1'b1);
        drain();

        $display("[TB] mul interlock");
        applyStimulus(1'b0, 1'b0, 1'b1, mul_i, 32'h400, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, add_i, 32'h404, 1'b1);
        t0 = cyc - 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            chk("md_in_ready", 64'(in_ready), 64'(0));
        end
        drain();
        tf = first_fire_after(t0);
        chk("md_gap", 64'(tf - t0), 64'(MD_LAT + 1));

        $display("[TB] flush");
        applyStimulus(1'b0, 1'b0, 1'b1, add_i, 32'h500, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, addi_i, 32'h504, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'(0));
        drain();
        applyStimulus(1'b0, 1'b0, 1'b1, mul_i, 32'h600, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        t0 = cyc - 1;
        applyStimulus(1'b0, 1'b1, 1'b1, addi_i, 32'h604, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, add_i, 32'h608, 1'b1);
        drain();
        tf = first_fire_after(t0);
        chk("flush_md_gap", 64'(tf - t0), 64'(MD_LAT + 1));

        $display("[TB] reset mid-interlock");
        applyStimulus(1'b0, 1'b0, 1'b1, mul_i, 32'h700, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, add_i, 32'h704, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready),  64'(1));
        chk("rst_ctrl",  64'(out_ctrl),  64'(0));
        chk("rst_pc",    64'(out_pc),    64'(0));
        applyStimulus(1'b0, 1'b0, 1'b1, add_i, 32'h710, 1'b1);
        chk("rst_md_clear", 64'(out_valid), 64'(1));
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 70, rand_insn(), $urandom,
                          $urandom_range(0, 99) < 70);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
